// File: rtl/alu_issue_ctrl_if.sv
// Bundle of instruction, ALU, retire, status and debug signals for alu_issue_ctrl.
interface alu_issue_ctrl_if;
    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 2;
    localparam int unsigned OPW = 2;
    localparam int unsigned CW  = 8;

    logic [DW-1:0]  instr;
    logic           instr_valid;
    logic           instr_ready;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic [DW-1:0]  alu_result;
    logic           alu_of;
    logic           done;
    logic           done_of;
    logic [DW-1:0]  wb_data;
    logic           of_sticky;
    logic [CW-1:0]  of_count;
    logic           clr_of;
    logic [AW-1:0]  dbg_sel;
    logic [DW-1:0]  dbg_data;

    modport slave (
        input  instr, instr_valid, alu_result, alu_of, clr_of, dbg_sel,
        output instr_ready, alu_a, alu_b, alu_op, done, done_of, wb_data,
               of_sticky, of_count, dbg_data
    );

    modport master (
        output instr, instr_valid, alu_result, alu_of, clr_of, dbg_sel,
        input  instr_ready, alu_a, alu_b, alu_op, done, done_of, wb_data,
               of_sticky, of_count, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: decodes an instruction, drives an external ALU,
// and retires into a 4x16 register file with overflow bookkeeping.
module alu_issue_ctrl (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 2;
    localparam int unsigned OPW  = 2;
    localparam int unsigned CW   = 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned IMMW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    state_e                   state_q,     state_d;
    logic [NREG-1:0][DW-1:0]  rf_q,        rf_d;
    logic [DW-1:0]            alu_a_q,     alu_a_d;
    logic [DW-1:0]            alu_b_q,     alu_b_d;
    logic [OPW-1:0]           alu_op_q,    alu_op_d;
    logic [AW-1:0]            rd_q,        rd_d;
    logic [DW-1:0]            res_q,       res_d;
    logic                     of_q,        of_d;
    logic                     ready_q,     ready_d;
    logic                     done_q,      done_d;
    logic                     done_of_q,   done_of_d;
    logic [DW-1:0]            wb_data_q,   wb_data_d;
    logic                     of_sticky_q, of_sticky_d;
    logic [CW-1:0]            of_count_q,  of_count_d;

    logic                     is_imm_c;
    logic [AW-1:0]            dec_rd_c;
    logic [AW-1:0]            dec_ra_c;
    logic [AW-1:0]            dec_rb_c;
    logic [OPW-1:0]           dec_op_c;
    logic [DW-1:0]            dec_imm_c;
    logic                     of_retire_c;

    // Instruction field decode; rd sits at the same position in both formats.
    always_comb begin
        is_imm_c  = bus.instr[15];
        dec_op_c  = bus.instr[14:13];
        dec_rd_c  = bus.instr[12:11];
        dec_ra_c  = bus.instr[10:9];
        dec_rb_c  = bus.instr[8:7];
        dec_imm_c = DW'(bus.instr[IMMW-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rf_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            of_q        <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            done_of_q   <= 1'b0;
            wb_data_q   <= '0;
            of_sticky_q <= 1'b0;
            of_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rf_q        <= rf_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            res_q       <= res_d;
            of_q        <= of_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            done_of_q   <= done_of_d;
            wb_data_q   <= wb_data_d;
            of_sticky_q <= of_sticky_d;
            of_count_q  <= of_count_d;
        end
    end

    // Retire outputs are loaded on entry to WB so they are high exactly in WB.
    always_comb begin
        state_d     = state_q;
        rf_d        = rf_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        res_d       = res_q;
        of_d        = of_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        done_of_d   = 1'b0;
        wb_data_d   = '0;
        of_sticky_d = of_sticky_q;
        of_count_d  = of_count_q;
        of_retire_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (bus.instr_valid) begin
                    ready_d = 1'b0;
                    rd_d    = dec_rd_c;
                    if (is_imm_c) begin
                        res_d     = dec_imm_c;
                        of_d      = 1'b0;
                        done_d    = 1'b1;
                        wb_data_d = dec_imm_c;
                        state_d   = ST_WB;
                    end else begin
                        alu_a_d  = rf_q[dec_ra_c];
                        alu_b_d  = rf_q[dec_rb_c];
                        alu_op_d = dec_op_c;
                        state_d  = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                res_d     = bus.alu_result;
                of_d      = bus.alu_of;
                done_d    = 1'b1;
                done_of_d = bus.alu_of;
                wb_data_d = bus.alu_of ? '0 : bus.alu_result;
                state_d   = ST_WB;
            end
            ST_WB: begin
                ready_d     = 1'b1;
                of_retire_c = of_q;
                if (!of_q) begin
                    rf_d[rd_q] = res_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear coinciding with an overflow retire still records that overflow.
        if (of_retire_c) begin
            of_sticky_d = 1'b1;
            if (bus.clr_of) begin
                of_count_d = CW'(1);
            end else if (of_count_q != '1) begin
                of_count_d = of_count_q + CW'(1);
            end
        end else if (bus.clr_of) begin
            of_sticky_d = 1'b0;
            of_count_d  = '0;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.done        = done_q;
    assign bus.done_of     = done_of_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.of_sticky   = of_sticky_q;
    assign bus.of_count    = of_count_q;
    assign bus.dbg_data    = rf_q[bus.dbg_sel];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stub, instruction-level reference model,
// per-cycle output comparison and directed plus randomized scenarios.
module tb_alu_issue_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {overflow, result}.
    function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] op);
        logic [31:0] wide;
        logic        of;
        logic [15:0] r;
        case (op)
            2'd0: begin wide = 32'(a) + 32'(b); of = (wide > 32'hFFFF); r = wide[15:0]; end
            2'd1: begin of = (b > a); r = a - b; end
            2'd2: begin wide = 32'(a) * 32'(b); of = (wide > 32'hFFFF); r = wide[15:0]; end
            default: begin of = (b == 16'd0); r = (b == 16'd0) ? 16'd0 : a / b; end
        endcase
        return {of, r};
    endfunction

    logic [16:0] alu_out;
    always_comb alu_out = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
    assign bus.alu_of     = alu_out[16];
    assign bus.alu_result = alu_out[15:0];

    function automatic logic [15:0] enc_alu(input logic [1:0] op, input logic [1:0] rd,
                                            input logic [1:0] ra, input logic [1:0] rb);
        return {1'b0, op, rd, ra, rb, 7'd0};
    endfunction

    function automatic logic [15:0] enc_li(input logic [1:0] rd, input logic [7:0] imm);
        return {1'b1, 2'b00, rd, 3'b000, imm};
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if ($urandom_range(0, 2) == 0) w[15] = 1'b1;
        else                           w[15] = 1'b0;
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one instruction in flight, counted down to its retire cycle.
    logic [15:0] m_r [4];
    logic        m_init;
    logic        m_busy;
    int          m_left;
    logic [1:0]  m_rd;
    logic [15:0] m_res;
    logic        m_of;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_op;
    logic        m_sticky;
    int          m_count;
    int          m_accepted;
    int          m_retired;

    initial begin
        m_init     = 1'b0;
        m_busy     = 1'b0;
        m_accepted = 0;
        m_retired  = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) m_r[i] = 16'd0;
            m_init = 1'b1; m_busy = 1'b0; m_left = 0; m_rd = 2'd0;
            m_res = 16'd0; m_of = 1'b0; m_a = 16'd0; m_b = 16'd0; m_op = 2'd0;
            m_sticky = 1'b0; m_count = 0;
        end else if (m_init) begin
            if (m_busy && m_left == 0) begin
                if (!m_of) m_r[m_rd] = m_res;
                if (m_of) begin
                    m_sticky = 1'b1;
                    m_count  = bus.clr_of ? 1 : ((m_count < 255) ? m_count + 1 : 255);
                end else if (bus.clr_of) begin
                    m_sticky = 1'b0; m_count = 0;
                end
                m_busy = 1'b0;
                m_retired++;
            end else begin
                if (bus.clr_of) begin m_sticky = 1'b0; m_count = 0; end
                if (m_busy) begin
                    m_left--;
                end else if (bus.instr_valid) begin
                    m_busy = 1'b1;
                    m_accepted++;
                    m_rd   = bus.instr[12:11];
                    if (bus.instr[15]) begin
                        m_res = {8'd0, bus.instr[7:0]}; m_of = 1'b0; m_left = 0;
                    end else begin
                        m_a  = m_r[bus.instr[10:9]];
                        m_b  = m_r[bus.instr[8:7]];
                        m_op = bus.instr[14:13];
                        {m_of, m_res} = alu_ref(m_a, m_b, m_op);
                        m_left = 1;
                    end
                end
            end
        end
    end

    logic stream_on;
    int   n_done;
    initial begin stream_on = 1'b0; n_done = 0; end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic        exp_done;
        if (m_init) begin
            exp_done = m_busy && (m_left == 0);
            chk("instr_ready", 32'(bus.instr_ready), 32'(!m_busy));
            chk("done",        32'(bus.done),        32'(exp_done));
            chk("done_of",     32'(bus.done_of),     32'(exp_done && m_of));
            chk("wb_data",     32'(bus.wb_data),     (exp_done && !m_of) ? 32'(m_res) : 32'd0);
            chk("alu_a",       32'(bus.alu_a),       32'(m_a));
            chk("alu_b",       32'(bus.alu_b),       32'(m_b));
            chk("alu_op",      32'(bus.alu_op),      32'(m_op));
            chk("of_sticky",   32'(bus.of_sticky),   32'(m_sticky));
            chk("of_count",    32'(bus.of_count),    32'(m_count));
            chk("dbg_data",    32'(bus.dbg_data),    32'(m_r[bus.dbg_sel]));
            if (stream_on && bus.done === 1'b1) n_done++;
        end
    end

    task automatic issue(input logic [15:0] ins, input logic clr_at_done,
                         output int lat, output logic [15:0] wb, output logic dof);
        logic acc;
        logic got;
        bus.instr       = ins;
        bus.instr_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin
            @(posedge clk);
            acc = bus.instr_ready;
        end
        #1 bus.instr_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        got = 1'b0; lat = 0; wb = 16'd0; dof = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                got = 1'b1; lat = k; wb = bus.wb_data; dof = bus.done_of;
                if (clr_at_done) bus.clr_of = 1'b1;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 bus.clr_of = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] wb;
        logic        dof;
        int          stream_acc;
        int          acc0, ret0;
        logic        acc;

        checks = 0; errors = 0;
        reset = 1'b1;
        bus.instr = 16'd0; bus.instr_valid = 1'b0; bus.clr_of = 1'b0; bus.dbg_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(bus.instr_ready), 32'd1);
        chk("reset_count", 32'(bus.of_count), 32'd0);
        chk("reset_done",  32'(bus.done), 32'd0);

        // R1=5, R2=3, R0=R1+R2
        @(posedge clk); #1;
        issue(enc_li(2'd1, 8'h05), 1'b0, lat, wb, dof);
        chk("li_latency", 32'(lat), 32'd1);
        issue(enc_li(2'd2, 8'h03), 1'b0, lat, wb, dof);
        issue(enc_alu(2'd0, 2'd0, 2'd1, 2'd2), 1'b0, lat, wb, dof);
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_wb", 32'(wb), 32'h0008);
        chk("add_dof", 32'(dof), 32'd0);
        bus.dbg_sel = 2'd0; @(negedge clk);
        chk("add_dbg_r0", 32'(bus.dbg_data), 32'h0008);

        // MUL without and with overflow
        @(posedge clk); #1;
        issue(enc_li(2'd1, 8'hFF), 1'b0, lat, wb, dof);
        issue(enc_alu(2'd2, 2'd3, 2'd1, 2'd1), 1'b0, lat, wb, dof);
        chk("mul_wb", 32'(wb), 32'hFE01);
        chk("mul_dof", 32'(dof), 32'd0);
        issue(enc_alu(2'd2, 2'd3, 2'd3, 2'd3), 1'b0, lat, wb, dof);
        chk("mul_of_dof", 32'(dof), 32'd1);
        chk("mul_of_wb", 32'(wb), 32'd0);
        bus.dbg_sel = 2'd3; @(negedge clk);
        chk("mul_of_r3_kept", 32'(bus.dbg_data), 32'hFE01);
        chk("mul_of_sticky", 32'(bus.of_sticky), 32'd1);
        chk("mul_of_count", 32'(bus.of_count), 32'd1);

        // Clear, then SUB underflow and DIV by zero
        @(posedge clk); #1 bus.clr_of = 1'b1;
        @(posedge clk); #1 bus.clr_of = 1'b0;
        issue(enc_li(2'd2, 8'h03), 1'b0, lat, wb, dof);
        issue(enc_li(2'd1, 8'h05), 1'b0, lat, wb, dof);
        issue(enc_alu(2'd1, 2'd0, 2'd2, 2'd1), 1'b0, lat, wb, dof);
        chk("sub_dof", 32'(dof), 32'd1);
        issue(enc_li(2'd2, 8'h00), 1'b0, lat, wb, dof);
        issue(enc_alu(2'd3, 2'd0, 2'd1, 2'd2), 1'b0, lat, wb, dof);
        chk("div0_dof", 32'(dof), 32'd1);
        @(negedge clk);
        chk("div0_count", 32'(bus.of_count), 32'd2);

        // Saturation, then clear coinciding with an overflow retire
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) issue(enc_alu(2'd3, 2'd0, 2'd1, 2'd2), 1'b0, lat, wb, dof);
        @(negedge clk);
        chk("sat_count", 32'(bus.of_count), 32'hFF);
        @(posedge clk); #1;
        issue(enc_alu(2'd3, 2'd0, 2'd1, 2'd2), 1'b1, lat, wb, dof);
        @(negedge clk);
        chk("clr_at_of_count", 32'(bus.of_count), 32'd1);
        chk("clr_at_of_sticky", 32'(bus.of_sticky), 32'd1);

        // instr_valid held high with random instructions
        @(posedge clk); #1;
        acc0 = m_accepted; ret0 = m_retired; stream_acc = 0; n_done = 0;
        stream_on = 1'b1;
        bus.instr = rand_instr(); bus.instr_valid = 1'b1;
        for (int c = 0; c < 2000 && stream_acc < 200; c++) begin
            @(posedge clk);
            acc = bus.instr_ready;
            #1;
            if (acc) begin stream_acc++; bus.instr = rand_instr(); end
            bus.clr_of  = ($urandom_range(0, 15) == 0);
            bus.dbg_sel = 2'($urandom_range(0, 3));
        end
        bus.instr_valid = 1'b0; bus.clr_of = 1'b0;
        repeat (4) @(posedge clk);
        #1 stream_on = 1'b0;
        chk("stream_accepts", 32'(stream_acc), 32'd200);
        chk("stream_model_accepts", 32'(m_accepted - acc0), 32'(stream_acc));
        chk("stream_done_count", 32'(n_done), 32'(m_retired - ret0));
        chk("stream_done_vs_accept", 32'(n_done), 32'(stream_acc));

        // Reset in EXEC of ADD R0=R1+R2 aborts it
        issue(enc_li(2'd1, 8'h05), 1'b0, lat, wb, dof);
        issue(enc_li(2'd2, 8'h03), 1'b0, lat, wb, dof);
        bus.dbg_sel = 2'd0;
        bus.instr = enc_alu(2'd0, 2'd0, 2'd1, 2'd2); bus.instr_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 20 && !acc; n++) begin @(posedge clk); acc = bus.instr_ready; end
        if (!acc) chk("rst_accept_timeout", 32'd0, 32'd1);
        #1 bus.instr_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_exec_done", 32'(bus.done), 32'd0);
        chk("rst_exec_r0", 32'(bus.dbg_data), 32'd0);
        chk("rst_exec_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_exec_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_exec_count", 32'(bus.of_count), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_exec_no_late_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        issue(enc_li(2'd3, 8'h5A), 1'b0, lat, wb, dof);
        chk("post_rst_li", 32'(wb), 32'h005A);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction word; valid only while instr_valid=1.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_op  out  2  ALU opcode: 00 add, 01 sub, 10 mul, 11 div.
- alu_result  in  16  combinational result from the ALU.
- alu_of  in  1  ALU overflow/error flag: add or mul result >0xFFFF, sub with B>A, div with B=0.
- done  out  1  one-cycle pulse when an instruction retires.
- done_of  out  1  valid with done; 1 = the instruction overflowed and was not written back.
- wb_data  out  16  value written on retire; 0 when done_of=1.
- of_sticky  out  1  sticky overflow status.
- of_count  out  8  saturating overflow count.
- clr_of  in  1  clears of_sticky and of_count.
- dbg_sel  in  2  register-file debug read index.
- dbg_data  out  16  combinational read of R[dbg_sel].
REQ-002 Parameters: none; register file is fixed at 4 x 16 bits (R0-R3).

Function
REQ-003 Instruction format: bit15 = I. I=0 (ALU): [14:13] op, [12:11] rd, [10:9] ra, [8:7] rb. I=1 (load-immediate): [12:11] rd, [7:0] imm, zero-extended to 16 bits; remaining bits are ignored.
REQ-004 FSM states: IDLE, EXEC, WB. instr_ready SHALL be 1 only in IDLE; an instruction is accepted when instr_valid=1 and instr_ready=1.
REQ-005 On acceptance of an ALU instruction: alu_a<=R[ra], alu_b<=R[rb], alu_op<=op, rd latched; IDLE->EXEC.
REQ-006 In EXEC: alu_result and alu_of are captured into internal registers; EXEC->WB.
REQ-007 On acceptance of a load-immediate instruction: the zero-extended imm and rd are latched, with captured overflow=0; IDLE->WB, skipping EXEC. alu_a, alu_b and alu_op are unchanged.
REQ-008 In WB: done=1, done_of=captured overflow, wb_data=captured result (0 if overflow). R[rd] is written only if overflow=0. WB->IDLE.
REQ-009 Latency from the accept edge to done: ALU instruction = 2 cycles; load-immediate = 1 cycle. Throughput: one instruction per 3 cycles (ALU) or 2 cycles (imm).
REQ-010 Operand reads SHALL see all earlier retired writes, because acceptance only occurs after WB completes. ra=rb=rd is legal.
REQ-011 On an overflow retire: of_sticky<=1 and of_count increments, saturating at 0xFF.
REQ-012 clr_of=1 clears of_sticky and of_count. If clr_of coincides with an overflow retire, the result SHALL be of_sticky=1, of_count=1.
REQ-013 alu_a, alu_b and alu_op SHALL hold their values outside EXEC; the ALU output is sampled only in EXEC.
REQ-014 dbg_data SHALL reflect a WB write from the cycle after the write edge.
REQ-015 done, done_of and wb_data SHALL be 0 in every cycle except WB.

Reset
REQ-016 reset=1 at a clock edge SHALL force the following, regardless of state: state=IDLE; R0-R3=0; alu_a=0, alu_b=0, alu_op=00; done=0, done_of=0, wb_data=0; of_sticky=0, of_count=0.
REQ-017 reset asserted in EXEC or WB SHALL abort the instruction with no done pulse and no register write.
REQ-018 reset SHALL take priority over instr_valid and clr_of. instr_ready=1 in the first cycle after reset deasserts.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- Load-imm R1=0x05, R2=0x03, then ADD R0=R1+R2 -> done 2 cycles after accept, wb_data=0x0008, dbg R0=0x0008, done_of=0.
- R1=0xFF, MUL R3=R1*R1 -> 0xFE01, no overflow. Then MUL R3=R3*R3 -> done_of=1, R3 stays 0xFE01, of_sticky=1, of_count=1.
- SUB R0=R2-R1 with R2=3, R1=5 -> done_of=1. DIV R0=R1/R2 with R2=0 -> done_of=1, of_count=2.
- 256 consecutive overflow instructions -> of_count saturates at 0xFF. clr_of on the same cycle as an overflow retire -> of_count=1, of_sticky=1.
- instr_valid held high continuously -> accepts only in IDLE, with exactly one done per instruction and no instruction lost or duplicated.
- reset pulsed in EXEC of ADD R0 -> no done, R0=0, all outputs at reset values, instr_ready=1 the next cycle.
